// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan decoder: segment patterns,
// special BCD codes, segment bit positions and FSM state encoding.
package seg7_pkg;

    // Patterns are seg_in[7:1] = {a, b, c, d, e, f, g}
    localparam logic [6:0] SEG7_0 = 7'b1111110;
    localparam logic [6:0] SEG7_1 = 7'b0110000;
    localparam logic [6:0] SEG7_2 = 7'b1101101;
    localparam logic [6:0] SEG7_3 = 7'b1111001;
    localparam logic [6:0] SEG7_4 = 7'b0110011;
    localparam logic [6:0] SEG7_5 = 7'b1011011;
    localparam logic [6:0] SEG7_6 = 7'b1011111;
    localparam logic [6:0] SEG7_7 = 7'b1110000;
    localparam logic [6:0] SEG7_8 = 7'b1111111;
    localparam logic [6:0] SEG7_9 = 7'b1111011;
    localparam logic [6:0] SEG7_OFF = 7'b0000000;

    localparam logic [3:0] BCD_INVALID = 4'hF;
    localparam logic [3:0] BCD_BLANK   = 4'hA;

    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        COLLECT   = 1'b1
    } state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational segment-pattern to BCD decoder.
// With SEG7_SCAN_BLANK_EN defined, the all-off pattern decodes to a valid blank.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [7:0] i_seg,
    output logic [3:0] o_bcd,
    output logic       o_valid,
    output logic       o_dp
);

    logic [6:0] w_pat;

    assign w_pat = i_seg[SEG_A:SEG_G];
    assign o_dp  = i_seg[SEG_DP];

    always_comb begin
        o_bcd   = BCD_INVALID;
        o_valid = 1'b0;
        case (w_pat)
            SEG7_0: begin o_bcd = 4'd0; o_valid = 1'b1; end
            SEG7_1: begin o_bcd = 4'd1; o_valid = 1'b1; end
            SEG7_2: begin o_bcd = 4'd2; o_valid = 1'b1; end
            SEG7_3: begin o_bcd = 4'd3; o_valid = 1'b1; end
            SEG7_4: begin o_bcd = 4'd4; o_valid = 1'b1; end
            SEG7_5: begin o_bcd = 4'd5; o_valid = 1'b1; end
            SEG7_6: begin o_bcd = 4'd6; o_valid = 1'b1; end
            SEG7_7: begin o_bcd = 4'd7; o_valid = 1'b1; end
            SEG7_8: begin o_bcd = 4'd8; o_valid = 1'b1; end
            SEG7_9: begin o_bcd = 4'd9; o_valid = 1'b1; end
`ifdef SEG7_SCAN_BLANK_EN
            SEG7_OFF: begin o_bcd = BCD_BLANK; o_valid = 1'b1; end
`endif
            default: begin
                o_bcd   = BCD_INVALID;
                o_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers BCD digits from a multiplexed 7-segment bus with ghost filtering and
// frame assembly. Optional macro SEG7_SCAN_BLANK_EN: all-off digit decodes as blank.
//
// state     | meaning
// WAIT_SYNC | discard acceptances until digit 0 starts a frame
// COLLECT   | capture accepted digits until every mask bit is set
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 3,
    parameter int STABLE_CNT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_en,
    input  logic [7:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     dp_out,
    output logic                  frame_valid,
    output logic                  frame_err
);

    localparam int         IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int         SAMP_W  = 8 + DIGITS;
    localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT);

    logic [3:0]               w_dec_bcd;
    logic                     w_dec_valid;
    logic                     w_dec_dp;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [SAMP_W-1:0]        r_prev;
    logic [3:0]               r_cnt;
    logic [3:0]               w_cnt_nxt;
    logic [DIGITS-1:0]        r_mask;
    logic [DIGITS-1:0]        w_mask_base;
    logic [DIGITS-1:0][3:0]   r_shadow_bcd;
    logic [DIGITS-1:0]        r_shadow_dp;
    logic                     r_err_acc;
    logic                     w_err_base;
    logic [DIGITS-1:0]        w_sel_m1;
    logic                     w_onehot;
    logic                     w_same;
    logic                     w_accept;
    logic                     w_capture;
    logic                     w_mask_full;
    logic [IDX_W-1:0]         w_idx;

    seg7_to_bcd u_dec (
        .i_seg   (seg_in),
        .o_bcd   (w_dec_bcd),
        .o_valid (w_dec_valid),
        .o_dp    (w_dec_dp)
    );

    assign w_sel_m1    = dig_sel - DIGITS'(1);
    assign w_onehot    = (dig_sel != '0) && ((dig_sel & w_sel_m1) == '0);
    assign w_same      = ({seg_in, dig_sel} == r_prev);
    assign w_mask_full = &r_mask;
    // A completed frame is flushed this edge, so a new capture starts from empty.
    assign w_mask_base = w_mask_full ? '0 : r_mask;
    assign w_err_base  = w_mask_full ? 1'b0 : r_err_acc;

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_accept  = 1'b0;
        if (sample_en) begin
            if (!w_onehot) begin
                w_cnt_nxt = 4'd0;
            end else if (w_same) begin
                if (r_cnt < CNT_MAX) begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
                w_accept = (r_cnt == CNT_MAX - 4'd1);
            end else begin
                w_cnt_nxt = 4'd1;
                w_accept  = (CNT_MAX == 4'd1);
            end
        end
    end

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_sel[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            WAIT_SYNC: begin
                if (w_accept && dig_sel[0]) begin
                    w_capture   = 1'b1;
                    w_state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                w_capture = w_accept;
            end
            default: begin
                w_state_nxt = WAIT_SYNC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WAIT_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev       <= '0;
            r_cnt        <= '0;
            r_mask       <= '0;
            r_shadow_bcd <= '0;
            r_shadow_dp  <= '0;
            r_err_acc    <= 1'b0;
            bcd_out      <= '0;
            dp_out       <= '0;
            frame_valid  <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            if (sample_en) begin
                r_prev <= {seg_in, dig_sel};
                r_cnt  <= w_cnt_nxt;
            end
            frame_valid <= w_mask_full;
            if (w_mask_full) begin
                bcd_out   <= r_shadow_bcd;
                dp_out    <= r_shadow_dp;
                frame_err <= r_err_acc;
            end
            if (w_capture) begin
                r_shadow_bcd[w_idx] <= w_dec_bcd;
                r_shadow_dp[w_idx]  <= w_dec_dp;
                r_mask              <= w_mask_base | dig_sel;
                r_err_acc           <= w_err_base | ~w_dec_valid;
            end else begin
                r_mask    <= w_mask_base;
                r_err_acc <= w_err_base;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder (DIGITS=3, STABLE_CNT=3) using a frame scoreboard.
// Honours SEG7_SCAN_BLANK_EN for the all-off digit expectation.
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_en;
    logic [7:0]  seg_in;
    logic [2:0]  dig_sel;
    logic [11:0] bcd_out;
    logic [2:0]  dp_out;
    logic        frame_valid;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [11:0] bcd;
        logic [2:0]  dp;
        logic        err;
    } exp_t;

    exp_t sb[$];

`ifdef SEG7_SCAN_BLANK_EN
    localparam logic [3:0] EXP_OFF     = 4'hA;
    localparam logic       EXP_OFF_ERR = 1'b0;
`else
    localparam logic [3:0] EXP_OFF     = 4'hF;
    localparam logic       EXP_OFF_ERR = 1'b1;
`endif

    seg7_scan_decoder #(.DIGITS(3), .STABLE_CNT(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_en   (sample_en),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .bcd_out     (bcd_out),
        .dp_out      (dp_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] seg_of(input int d, input logic dp);
        logic [6:0] p;
        case (d)
            0: p = 7'b1111110;
            1: p = 7'b0110000;
            2: p = 7'b1101101;
            3: p = 7'b1111001;
            4: p = 7'b0110011;
            5: p = 7'b1011011;
            6: p = 7'b1011111;
            7: p = 7'b1110000;
            8: p = 7'b1111111;
            9: p = 7'b1111011;
            default: p = 7'b0000000;
        endcase
        return {p, dp};
    endfunction

    // Scoreboard comparator: every frame_valid pulse must match the oldest expected frame.
    always @(negedge clk) begin : mon
        exp_t e;
        if (frame_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame bcd_out=%h dp_out=%b frame_err=%b", bcd_out, dp_out, frame_err);
            end else begin
                e = sb.pop_front();
                if (bcd_out !== e.bcd) begin
                    errors++;
                    $display("FAIL frame_bcd got=%h exp=%h", bcd_out, e.bcd);
                end
                checks++;
                if (dp_out !== e.dp) begin
                    errors++;
                    $display("FAIL frame_dp got=%b exp=%b", dp_out, e.dp);
                end
                checks++;
                if (frame_err !== e.err) begin
                    errors++;
                    $display("FAIL frame_err got=%b exp=%b", frame_err, e.err);
                end
            end
        end
    end

    task automatic step(input logic en, input logic [7:0] seg, input logic [2:0] sel);
        sample_en = en;
        seg_in    = seg;
        dig_sel   = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] seg, input int dig, input int n);
        for (int i = 0; i < n; i++) step(1'b1, seg, 3'(1 << dig));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 3'b000);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step(1'b0, 8'h00, 3'b000);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (bcd_out !== 12'h000) begin errors++; $display("FAIL reset_bcd got=%h exp=000", bcd_out); end
        checks++;
        if (dp_out !== 3'b000) begin errors++; $display("FAIL reset_dp got=%b exp=000", dp_out); end
        checks++;
        if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", frame_valid); end
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", frame_err); end
    endtask

    task automatic test_frame_capture();
        apply_reset();
        send(seg_of(5, 1'b0), 0, 3);
        send(seg_of(2, 1'b0), 1, 3);
        send(seg_of(1, 1'b0), 2, 2);
        sb.push_back({12'h125, 3'b000, 1'b0});
        send(seg_of(1, 1'b0), 2, 1);
        checks++;
        if (frame_valid !== 1'b0) begin errors++; $display("FAIL latency_early got=%b exp=0", frame_valid); end
        idle(1);
        checks++;
        if (frame_valid !== 1'b1) begin errors++; $display("FAIL latency_pulse got=%b exp=1", frame_valid); end
        checks++;
        if (bcd_out !== 12'h125) begin errors++; $display("FAIL capture_bcd got=%h exp=125", bcd_out); end
        idle(1);
        checks++;
        if (frame_valid !== 1'b0) begin errors++; $display("FAIL pulse_width got=%b exp=0", frame_valid); end
        checks++;
        if (bcd_out !== 12'h125) begin errors++; $display("FAIL hold_bcd got=%h exp=125", bcd_out); end
        idle(3);
    endtask

    task automatic test_ghosting();
        int seen;
        seen = 0;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, (i % 2 == 0) ? seg_of(8, 1'b0) : seg_of(0, 1'b0), 3'b001);
            if (frame_valid === 1'b1) seen++;
        end
        // Two matching samples, a blank, two more: never reaches three in a row.
        send(seg_of(4, 1'b0), 0, 2);
        step(1'b1, seg_of(4, 1'b0), 3'b000);
        send(seg_of(4, 1'b0), 0, 2);
        send(seg_of(7, 1'b0), 1, 3);
        send(seg_of(3, 1'b0), 2, 3);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            if (frame_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL ghost_pulses got=%0d exp=0", seen); end
        checks++;
        if (bcd_out !== 12'h000) begin errors++; $display("FAIL ghost_bcd got=%h exp=000", bcd_out); end
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL ghost_err got=%b exp=0", frame_err); end
        send(seg_of(4, 1'b0), 0, 6);
        send(seg_of(7, 1'b0), 1, 3);
        sb.push_back({12'h374, 3'b000, 1'b0});
        send(seg_of(3, 1'b0), 2, 3);
        idle(3);
    endtask

    task automatic test_invalid_dp();
        apply_reset();
        send(seg_of(0, 1'b1), 0, 3);
        send(8'b0000001_0, 1, 3);
        sb.push_back({{EXP_OFF, 4'hF, 4'h0}, 3'b001, 1'b1});
        send(8'h00, 2, 3);
        idle(3);
        send(seg_of(3, 1'b0), 0, 3);
        send(seg_of(7, 1'b1), 1, 3);
        sb.push_back({{EXP_OFF, 4'h7, 4'h3}, 3'b010, EXP_OFF_ERR});
        send(8'h00, 2, 3);
        idle(3);
        checks++;
        if (dp_out !== 3'b010) begin errors++; $display("FAIL dp_hold got=%b exp=010", dp_out); end
    endtask

    task automatic test_sync();
        int seen;
        seen = 0;
        apply_reset();
        send(seg_of(1, 1'b0), 1, 3);
        send(seg_of(2, 1'b0), 2, 3);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            if (frame_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL sync_early got=%0d exp=0", seen); end
        send(seg_of(9, 1'b0), 0, 3);
        send(seg_of(4, 1'b0), 1, 3);
        sb.push_back({12'h649, 3'b000, 1'b0});
        send(seg_of(6, 1'b0), 2, 3);
        idle(3);
    endtask

    task automatic test_reset_mid_frame();
        int seen;
        seen = 0;
        apply_reset();
        send(seg_of(6, 1'b0), 0, 3);
        step(1'b1, seg_of(6, 1'b0), 3'b000);
        send(seg_of(5, 1'b0), 1, 3);
        apply_reset();
        checks++;
        if (bcd_out !== 12'h000) begin errors++; $display("FAIL midrst_bcd got=%h exp=000", bcd_out); end
        send(seg_of(2, 1'b0), 2, 3);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            if (frame_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL midrst_pulse got=%0d exp=0", seen); end
        send(seg_of(8, 1'b0), 0, 3);
        step(1'b1, seg_of(8, 1'b0), 3'b011);
        send(seg_of(0, 1'b0), 1, 3);
        step(1'b1, seg_of(0, 1'b0), 3'b000);
        sb.push_back({12'h708, 3'b000, 1'b0});
        send(seg_of(7, 1'b0), 2, 3);
        idle(3);
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL blank_err got=%b exp=0", frame_err); end
    endtask

    task automatic test_back_to_back();
        send(seg_of(1, 1'b0), 0, 3);
        send(seg_of(2, 1'b0), 1, 3);
        sb.push_back({12'h321, 3'b000, 1'b0});
        send(seg_of(3, 1'b0), 2, 3);
        send(seg_of(9, 1'b0), 0, 3);
        send(seg_of(8, 1'b1), 1, 3);
        sb.push_back({12'h089, 3'b010, 1'b0});
        send(seg_of(0, 1'b0), 2, 3);
        idle(4);
    endtask

    initial begin
        rst       = 1'b1;
        sample_en = 1'b0;
        seg_in    = 8'h00;
        dig_sel   = 3'b000;
        test_reset();
        test_frame_capture();
        test_ghosting();
        test_invalid_dp();
        test_sync();
        test_reset_mid_frame();
        test_back_to_back();
        idle(4);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_frames got=%0d pending exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the BCD-to-7-segment coder: watches the multiplexed display bus (segment pattern plus one-hot digit select) and recovers the displayed BCD digits.
- Filters scan ghosting with a stability counter, assembles one full scan frame, and presents it as a packed BCD word with a one-cycle valid pulse.
- Used for display self-test and loopback checking of the counter display path.

Parameters:
- DIGITS, 3, number of multiplexed digits; digit 0 is least significant.
- STABLE_CNT, 3, consecutive identical samples (pattern and select) required to accept a digit; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- sample_en  input  1  seg_in/dig_sel are valid this cycle.
- seg_in  input  8  active-high segments: bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp.
- dig_sel  input  DIGITS  one-hot active-high digit select.
- bcd_out  output  4*DIGITS  packed BCD; nibble i = digit i.
- dp_out  output  DIGITS  decimal-point bit per digit.
- frame_valid  output  1  one-cycle pulse when bcd_out/dp_out/frame_err update.
- frame_err  output  1  at least one digit in the frame had an undecodable pattern.

Behaviour:
- Reset (rst=1 at an edge): bcd_out=0, dp_out=0, frame_valid=0, frame_err=0. Stability counter, previous-sample register, captured mask, shadow registers and error accumulator all clear. FSM goes to WAIT_SYNC. Reset mid-frame discards the partial frame.
- Decode uses seg_in[7:1] only. 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011. dp = seg_in[0].
- Any other pattern decodes to 4'hF and is marked invalid.
- Stability rule:
  - sample_en=0: hold all state.
  - sample_en=1 with dig_sel not one-hot (zero or multiple bits): blanking. Counter <= 0, no capture, no error.
  - sample_en=1 with one-hot dig_sel equal to the previous sample's {seg_in, dig_sel}: counter increments, saturating at STABLE_CNT.
  - sample_en=1 with one-hot dig_sel that differs from the previous sample: counter <= 1.
  - Acceptance happens on the edge where the counter goes from STABLE_CNT-1 to STABLE_CNT. With STABLE_CNT=1, every changed sample is accepted.
  - A saturated counter does not re-accept.
- FSM:
  - WAIT_SYNC: acceptances of digits other than 0 are ignored. Acceptance of digit 0 writes shadow[0], sets mask bit 0, and moves to COLLECT.
  - COLLECT: each acceptance writes shadow[i], dp[i] and the invalid flag, and sets mask bit i. Re-acceptance of an already-captured digit overwrites it silently.
  - Frame complete: when the mask, including the current acceptance, becomes all ones, on the next edge bcd_out<=shadow, dp_out<=dp shadow, frame_err<=OR of invalid flags, frame_valid<=1. Mask and error accumulator clear and the FSM stays in COLLECT.
  - An acceptance on that same edge counts toward the new frame.
- Latency: frame_valid is high exactly one cycle after the edge that registered the completing acceptance. It is 0 on every other cycle. Outputs hold between frames.

Optional Feature:
- Macro SEG7_SCAN_BLANK_EN.
- Defined: all-off pattern seg_in[7:1]=0000000 decodes to 4'hA (blank) and is valid, which supports leading-zero blanking.
- Undefined: the all-off pattern decodes to 4'hF and is invalid, so frame_err is set.

Decomposition:
- Package seg7_pkg holds:
  - segment-pattern constants SEG7_0..SEG7_9;
  - BCD_INVALID=4'hF and BCD_BLANK=4'hA;
  - segment bit-index constants;
  - FSM state encoding WAIT_SYNC/COLLECT.
- Sub-module seg7_to_bcd: purely combinational, seg_in -> {bcd[3:0], valid, dp}. The top level holds all sequential logic.

Test Plan:
- Frame capture: DIGITS=3, STABLE_CNT=3. Digit0 gets 1011011_0 (5) x3, digit1 gets 1101101_0 (2) x3, digit2 gets 0110000_0 (1) x3, all with sample_en=1 -> frame_valid pulses the cycle after the 9th sample, bcd_out=12'h125, frame_err=0.
- Ghosting: digit0 pattern alternates 8/0 every sample for 20 cycles -> no acceptance, frame_valid never asserts, outputs stay at reset values.
- Invalid and dp: digit1 gets 0000001_0 (g only) and digit0 gets 1111110_1 (0 with dp) -> nibble1=F, nibble0=0, dp_out=3'b001, frame_err=1. With SEG7_SCAN_BLANK_EN, an all-off digit2 gives nibble2=A and frame_err unaffected by it.
- Sync: scan starts at digit1 -> digit1/digit2 acceptances ignored until digit0 is accepted. The first frame_valid comes only after a full 0->1->2 frame.
- Reset mid-frame: rst=1 for 1 cycle after digit0 and digit1 are accepted -> bcd_out=0, no frame_valid until a complete new frame. Blanking samples (dig_sel=0) inserted between digits do not cause errors.
